// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the instruction/data memory bus arbiter.
package mem_bus_arbiter_pkg;

    localparam int unsigned ArbStateBus = 3;
    localparam int unsigned SelW        = 4;

    typedef enum logic [ArbStateBus-1:0] {
        ArbIdle,
        ArbGntIf,
        ArbGntData,
        ArbRspIf,
        ArbRspData
    } arb_state_e;

    typedef enum logic {
        GrantIf   = 1'b0,
        GrantData = 1'b1
    } grant_e;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Shares one single-port synchronous RAM between the fetch and data ports.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise data wins ties.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [SelW-1:0]   data_sel,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_ack,
    output logic [DATA_W-1:0] data_rdata,
    output logic              stall_if,
    output logic              stall_data,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [SelW-1:0]   ram_sel,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    arb_state_e state_q, state_d;
    logic       tie_to_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ArbIdle;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef MEM_ARB_RR_EN
    grant_e last_q, last_d;

    // Reset value IF makes data the winner of the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= GrantIf;
        end else begin
            last_q <= last_d;
        end
    end

    always_comb begin
        last_d = last_q;
        if (state_d == ArbGntIf) begin
            last_d = GrantIf;
        end else if (state_d == ArbGntData) begin
            last_d = GrantData;
        end
    end

    assign tie_to_data = (last_q == GrantIf);
`else
    assign tie_to_data = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ArbIdle: begin
                if (data_req && (!if_req || tie_to_data)) begin
                    state_d = ArbGntData;
                end else if (if_req) begin
                    state_d = ArbGntIf;
                end
            end
            ArbGntIf:   state_d = ArbRspIf;
            ArbGntData: state_d = ArbRspData;
            // The acked port's request is ignored so the other port gets its turn.
            ArbRspIf:   state_d = data_req ? ArbGntData : ArbIdle;
            ArbRspData: state_d = if_req ? ArbGntIf : ArbIdle;
            default:    state_d = ArbIdle;
        endcase
    end

    always_comb begin
        ram_ce     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_sel    = '0;
        ram_wdata  = '0;
        if_ack     = 1'b0;
        if_rdata   = '0;
        data_ack   = 1'b0;
        data_rdata = '0;
        case (state_q)
            ArbGntIf: begin
                ram_ce   = 1'b1;
                ram_addr = if_addr;
                ram_sel  = {SelW{1'b1}};
            end
            ArbGntData: begin
                ram_ce    = 1'b1;
                ram_we    = data_we;
                ram_addr  = data_addr;
                ram_sel   = data_sel;
                ram_wdata = data_wdata;
            end
            ArbRspIf: begin
                if_ack   = 1'b1;
                if_rdata = ram_rdata;
            end
            ArbRspData: begin
                data_ack   = 1'b1;
                data_rdata = ram_rdata;
            end
            default: ;
        endcase
    end

    assign stall_if   = if_req & ~if_ack;
    assign stall_data = data_req & ~data_ack;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a byte-lane RAM model.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        data_req;
    logic        data_we;
    logic [31:0] data_addr;
    logic [3:0]  data_sel;
    logic [31:0] data_wdata;
    logic        data_ack;
    logic [31:0] data_rdata;
    logic        stall_if;
    logic        stall_data;
    logic        ram_ce;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [3:0]  ram_sel;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    logic        mem_load;
    logic [31:0] mem [0:63];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .ADDR_W(32),
        .DATA_W(32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .data_req  (data_req),
        .data_we   (data_we),
        .data_addr (data_addr),
        .data_sel  (data_sel),
        .data_wdata(data_wdata),
        .data_ack  (data_ack),
        .data_rdata(data_rdata),
        .stall_if  (stall_if),
        .stall_data(stall_data),
        .ram_ce    (ram_ce),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_sel   (ram_sel),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // Synchronous RAM: read data appears the cycle after ram_ce.
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 64; i++) begin
                mem[i] <= 32'h1000_0000 + i;
            end
            mem[4]    <= 32'h3401_0020;
            mem[16]   <= 32'h1122_3344;
            ram_rdata <= '0;
        end else if (ram_ce) begin
            ram_rdata <= mem[ram_addr[7:2]];
            if (ram_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_sel[b]) mem[ram_addr[7:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Called 1 time unit after a rising edge with the arbiter idle.
    task automatic access(input logic is_data, input logic we, input logic [31:0] addr,
                          input logic [3:0] sel, input logic [31:0] wdata,
                          input logic chk_rd, input logic [31:0] exp_rd, input string name);
        logic got;
        logic ack;
        got = 1'b0;
        if (is_data) begin
            data_req   = 1'b1;
            data_we    = we;
            data_addr  = addr;
            data_sel   = sel;
            data_wdata = wdata;
        end else begin
            if_req  = 1'b1;
            if_addr = addr;
        end
        for (int c = 0; c < 8 && !got; c++) begin
            @(negedge clk);
            ack = is_data ? data_ack : if_ack;
            check({name, " stall"}, {31'b0, is_data ? stall_data : stall_if}, {31'b0, ~ack});
            check({name, " other_ack"}, {31'b0, is_data ? if_ack : data_ack}, 32'd0);
            if (c == 0) check({name, " idle_ce"}, {31'b0, ram_ce}, 32'd0);
            if (c == 1) begin
                check({name, " gnt_ce"}, {31'b0, ram_ce}, 32'd1);
                check({name, " gnt_addr"}, ram_addr, addr);
                check({name, " gnt_we"}, {31'b0, ram_we}, {31'b0, is_data & we});
                if (is_data && we) begin
                    check({name, " gnt_sel"}, {28'b0, ram_sel}, {28'b0, sel});
                    check({name, " gnt_wdata"}, ram_wdata, wdata);
                end
            end
            if (ack) begin
                got = 1'b1;
                check({name, " latency"}, c, 32'd2);
                if (chk_rd) check({name, " rdata"}, is_data ? data_rdata : if_rdata, exp_rd);
            end
            @(posedge clk);
            #1;
        end
        if (!got) check({name, " ack_timeout"}, 32'd0, 32'd1);
        if_req   = 1'b0;
        data_req = 1'b0;
    endtask

    typedef struct {
        logic        is_data;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int  n_ack;
        logic prev_data;
        logic a_data;

        vecs[0] = '{1'b0, 1'b0, 32'h10, 4'h0, 32'h0,          1'b1, 32'h3401_0020};
        vecs[1] = '{1'b1, 1'b1, 32'h40, 4'b0011, 32'hAABB_CCDD, 1'b0, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h40, 4'h0, 32'h0,          1'b1, 32'h1122_CCDD};
        vecs[3] = '{1'b1, 1'b1, 32'h44, 4'b1111, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vecs[4] = '{1'b1, 1'b0, 32'h44, 4'h0, 32'h0,          1'b1, 32'hDEAD_BEEF};
        vecs[5] = '{1'b1, 1'b1, 32'h44, 4'b1000, 32'h0102_0304, 1'b0, 32'h0};
        vecs[6] = '{1'b1, 1'b0, 32'h44, 4'h0, 32'h0,          1'b1, 32'h01AD_BEEF};
        vecs[7] = '{1'b1, 1'b1, 32'h48, 4'b0100, 32'h0055_0000, 1'b0, 32'h0};
        vecs[8] = '{1'b1, 1'b0, 32'h48, 4'h0, 32'h0,          1'b1, 32'h1055_0012};
        vecs[9] = '{1'b0, 1'b0, 32'h48, 4'h0, 32'h0,          1'b1, 32'h1055_0012};

        rst = 1'b1; mem_load = 1'b1;
        if_req = 1'b1; if_addr = 32'h10;
        data_req = 1'b1; data_we = 1'b1; data_addr = 32'h40;
        data_sel = 4'hF; data_wdata = 32'hFFFF_FFFF;

        // Reset held with both requests high: nothing reaches the RAM.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst ram_ce", {31'b0, ram_ce}, 32'd0);
            check("rst ram_we", {31'b0, ram_we}, 32'd0);
            check("rst ram_addr", ram_addr, 32'd0);
            check("rst ram_sel", {28'b0, ram_sel}, 32'd0);
            check("rst ram_wdata", ram_wdata, 32'd0);
            check("rst acks", {30'b0, if_ack, data_ack}, 32'd0);
            check("rst rdata", if_rdata | data_rdata, 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0; mem_load = 1'b0;
        if_req = 1'b0; data_req = 1'b0; data_we = 1'b0;

        for (int v = 0; v < 10; v++) begin
            access(vecs[v].is_data, vecs[v].we, vecs[v].addr, vecs[v].sel, vecs[v].wdata,
                   vecs[v].chk_rd, vecs[v].exp_rd, $sformatf("vec%0d", v));
        end

        // Simultaneous requests after reset: data first, fetch handed off right after.
        do_reset();
        if_req = 1'b1; if_addr = 32'h10;
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h40;
        @(negedge clk);
        check("tie c0 ce", {31'b0, ram_ce}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("tie c1 addr", ram_addr, 32'h40);
        @(posedge clk); #1;
        @(negedge clk);
        check("tie c2 acks", {30'b0, if_ack, data_ack}, 32'd1);
        check("tie c2 rdata", data_rdata, 32'h1122_CCDD);
        check("tie c2 stall_if", {31'b0, stall_if}, 32'd1);
        @(posedge clk); #1;
        data_req = 1'b0;
        @(negedge clk);
        check("tie c3 addr", ram_addr, 32'h10);
        check("tie c3 acks", {30'b0, if_ack, data_ack}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("tie c4 acks", {30'b0, if_ack, data_ack}, 32'd2);
        check("tie c4 rdata", if_rdata, 32'h3401_0020);
        @(posedge clk); #1;
        if_req = 1'b0;

        // Continuous contention: one ack every other cycle, alternating, data first.
        do_reset();
        if_req = 1'b1; if_addr = 32'h10;
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h40;
        n_ack = 0;
        prev_data = 1'b0;
        @(negedge clk);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            check($sformatf("cont c%0d both_ack", c), {31'b0, if_ack & data_ack}, 32'd0);
            check($sformatf("cont c%0d ack_slot", c), {31'b0, if_ack | data_ack},
                  {31'b0, (c % 2) == 0});
            if (if_ack || data_ack) begin
                a_data = data_ack;
                check($sformatf("cont c%0d alternate", c), {31'b0, a_data}, {31'b0, ~prev_data});
                prev_data = a_data;
                n_ack++;
            end
        end
        check("cont ack_total", n_ack, 32'd10);
        @(posedge clk); #1;
        if_req = 1'b0; data_req = 1'b0;
        do_reset();

        // Reset during GNT_IF aborts the fetch; a fresh fetch then completes normally.
        if_req = 1'b1; if_addr = 32'h10;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check("abort gnt_ce", {31'b0, ram_ce}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        access(1'b0, 1'b0, 32'h10, 4'h0, 32'h0, 1'b1, 32'h3401_0020, "refetch");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
